// File: rtl/ctrl_frame_sender.sv
// Control-frame sender: picosoc-mapped frame buffer and config register. A send
// streams the body bytes into the TX body FIFO first, then writes one header word.
module ctrl_frame_sender #(
    parameter int HEADER_DWIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [HEADER_DWIDTH-1:0] h_fifo_din,
    output logic                     h_fifo_wren,
    input  logic                     h_fifo_full,
    output logic [7:0]               b_fifo_din,
    output logic                     b_fifo_wren,
    output logic                     b_fifo_del,
    input  logic                     b_fifo_full,
    input  logic                     iomem_valid,
    output logic                     iomem_ready,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic [31:0]              iomem_rdata
);
    localparam logic [7:0] REG_REGION = 8'h15;
    localparam logic [7:0] BUF_REGION = 8'h05;
    localparam logic [6:0] MAX_LEN    = 7'd48;
    localparam logic [6:0] RST_LEN    = 7'd46;

    typedef enum logic [1:0] {IDLE, BODY, HEADER, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] mem [16];
    logic [6:0]  body_len, frame_len, eff_len;
    logic [5:0]  cnt;
    logic [3:0]  body_idx;
    logic [31:0] body_word, cfg_rd;
    logic [7:0]  body_byte;
    logic [127:0] hdr;
    logic        err, busy, last_byte;
    logic        is_reg, is_buf, access, cfg_wr;
    logic        send_req, clr_req, send_ok, err_set, buf_wr;
    logic        unused_addr;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign unused_addr = ^{iomem_addr[23:6], iomem_addr[1:0]};

    assign busy   = (state != IDLE);
    assign is_reg = (iomem_addr[31:24] == REG_REGION);
    assign is_buf = (iomem_addr[31:24] == BUF_REGION);
    // Requests to foreign regions are never acknowledged.
    assign access = iomem_valid && !iomem_ready && (is_reg || is_buf);
    assign cfg_wr = access && is_reg;

    assign send_req = cfg_wr && iomem_wstrb[3] && iomem_wdata[30];
    assign clr_req  = cfg_wr && iomem_wstrb[3] && iomem_wdata[27];
    assign eff_len  = iomem_wstrb[0] ? iomem_wdata[6:0] : body_len;
    assign send_ok  = send_req && !busy && (eff_len != 7'd0);
    assign buf_wr   = access && is_buf && (iomem_wstrb != 4'd0) && !busy;
    // Set has priority over clear when both arrive together.
    assign err_set  = (send_req && !send_ok) ||
                      (access && is_buf && (iomem_wstrb != 4'd0) && busy);

    assign cfg_rd = {busy, 3'b000, err, 20'd0, body_len};

    assign body_idx  = 4'd4 + cnt[5:2];
    assign body_word = mem[body_idx];
    assign body_byte = body_word[{cnt[1:0], 3'b000} +: 8];
    assign last_byte = (cnt == 6'(frame_len - 7'd1));

    always_comb begin
        hdr = {swap(mem[0]), swap(mem[1]), swap(mem[2]), swap(mem[3])};
        hdr[114] = 1'b1;
        hdr[115] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        b_fifo_wren = 1'b0;
        b_fifo_din  = 8'd0;
        b_fifo_del  = 1'b0;
        h_fifo_wren = 1'b0;
        h_fifo_din  = '0;
        case (state)
            IDLE: if (send_ok) state_next = BODY;
            BODY: begin
                if (!b_fifo_full) begin
                    b_fifo_wren = 1'b1;
                    b_fifo_din  = body_byte;
                    b_fifo_del  = last_byte;
                    if (last_byte) state_next = HEADER;
                end
            end
            HEADER: begin
                h_fifo_din = HEADER_DWIDTH'(hdr);
                if (!h_fifo_full) begin
                    h_fifo_wren = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'd0;
            body_len    <= RST_LEN;
            err         <= 1'b0;
            frame_len   <= 7'd0;
            cnt         <= 6'd0;
        end else begin
            iomem_ready <= access;
            if (access) iomem_rdata <= is_reg ? cfg_rd : mem[iomem_addr[5:2]];
            if (cfg_wr && iomem_wstrb[0]) body_len <= iomem_wdata[6:0];
            if (err_set)      err <= 1'b1;
            else if (clr_req) err <= 1'b0;
            if (send_ok) begin
                frame_len <= (eff_len > MAX_LEN) ? MAX_LEN : eff_len;
                cnt       <= 6'd0;
            end else if (b_fifo_wren) begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            for (int i = 0; i < 4; i++)
                if (iomem_wstrb[i]) mem[iomem_addr[5:2]][8*i +: 8] <= iomem_wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_ctrl_frame_sender.sv
// Scoreboard bench for ctrl_frame_sender: a byte-level buffer model predicts
// the FIFO stream and register reads; a negedge monitor checks every FIFO write.
module tb_ctrl_frame_sender;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] h_fifo_din;
    logic         h_fifo_wren;
    logic         h_fifo_full = 1'b0;
    logic [7:0]   b_fifo_din;
    logic         b_fifo_wren, b_fifo_del;
    logic         b_fifo_full = 1'b0;
    logic         iomem_valid = 1'b0;
    logic         iomem_ready;
    logic [3:0]   iomem_wstrb = 4'd0;
    logic [31:0]  iomem_addr = 32'd0;
    logic [31:0]  iomem_wdata = 32'd0;
    logic [31:0]  iomem_rdata;

    ctrl_frame_sender #(.HEADER_DWIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .h_fifo_din(h_fifo_din), .h_fifo_wren(h_fifo_wren), .h_fifo_full(h_fifo_full),
        .b_fifo_din(b_fifo_din), .b_fifo_wren(b_fifo_wren), .b_fifo_del(b_fifo_del),
        .b_fifo_full(b_fifo_full),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit           is_hdr;
        logic [127:0] data;
        int           idx;
    } exp_t;
    exp_t q[$];

    // reference model: buffer as 64 little-endian bytes
    logic [7:0] mbuf [64];
    bit         mb = 1'b0;
    bit         err_m = 1'b0;
    logic [6:0] len_m = 7'd46;
    int         t_acc = 0;
    int         first_body_cyc = 0;
    int         hdr_cyc = 0;
    bit         bp_en = 1'b0;
    int         stall_from = 0;
    int         stall_to = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mword(input int i);
        return {mbuf[4*i+3], mbuf[4*i+2], mbuf[4*i+1], mbuf[4*i]};
    endfunction

    function automatic logic [31:0] mcfg();
        return {mb, 3'b000, err_m, 20'd0, len_m};
    endfunction

    // Header = buffer bytes 0..15 with byte 0 most significant, plus the two flag bits.
    task automatic push_frame(input int n);
        exp_t e;
        logic [127:0] h;
        for (int k = 0; k < n; k++) begin
            e.is_hdr = 1'b0;
            e.data   = 128'({(k == n - 1), mbuf[16 + k]});
            e.idx    = k;
            q.push_back(e);
        end
        h = '0;
        for (int j = 0; j < 16; j++) h = {h[119:0], mbuf[j]};
        h[114] = 1'b1;
        h[115] = 1'b1;
        e.is_hdr = 1'b1;
        e.data   = h;
        e.idx    = n;
        q.push_back(e);
    endtask

    // Monitor: every FIFO write must match the head of the expected stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_fifo_wren) begin
                if (q.size() == 0) check("body_unexpected", 128'(b_fifo_din), 128'h1_0000);
                else begin
                    e = q.pop_front();
                    if (e.is_hdr) check("body_before_hdr_order", 128'(b_fifo_din), e.data);
                    else begin
                        if (e.idx == 0) first_body_cyc = cyc + 1;
                        check("body_byte_del", 128'({b_fifo_del, b_fifo_din}), e.data);
                    end
                end
            end
            if (h_fifo_wren) begin
                if (q.size() == 0) check("hdr_unexpected", h_fifo_din, 128'h0);
                else begin
                    e = q.pop_front();
                    if (!e.is_hdr) check("hdr_before_body_end", 128'(e.idx), 128'hFFFF);
                    else begin
                        hdr_cyc = cyc + 1;
                        check("header_word", h_fifo_din, e.data);
                    end
                end
            end
        end
    end

    // Backpressure driver: scheduled stall window plus optional random stalls.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            b_fifo_full = (cyc >= stall_from && cyc < stall_to) ||
                          (bp_en && $urandom_range(0, 3) == 0);
            h_fifo_full = bp_en && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        bit ok;
        ok = 1'b0;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) ok = 1'b1;
        end
        r = iomem_rdata;
        iomem_valid = 1'b0;
        if (!ok) check("bus_timeout", 128'(ok), 128'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        logic [6:0]  effl;
        bit          send, fail;
        bus(a, s, d, r);
        if (a[31:24] == 8'h15) begin
            effl = s[0] ? d[6:0] : len_m;
            if (s[0]) len_m = d[6:0];
            send = s[3] && d[30];
            fail = send && (mb || effl == 7'd0);
            if (fail) err_m = 1'b1;
            else if (s[3] && d[27]) err_m = 1'b0;
            if (send && !fail) begin
                push_frame((effl > 7'd48) ? 48 : int'(effl));
                mb    = 1'b1;
                t_acc = cyc;
            end
        end else if (a[31:24] == 8'h05 && s != 4'd0) begin
            if (mb) err_m = 1'b1;
            else for (int b = 0; b < 4; b++)
                if (s[b]) mbuf[4*int'(a[5:2]) + b] = d[8*b +: 8];
        end
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 4'd0, 32'd0, r);
        check(nm, 128'(r), 128'(exp));
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 2000 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() > 0) check("frame_timeout", 128'(q.size()), 128'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mb = 1'b0;
        rd(nm, 32'h1500_0000, mcfg());
    endtask

    task automatic fill_buffer();
        for (int w = 0; w < 16; w++) wr(32'h0500_0000 | 32'(w << 2), 4'hF, $urandom);
    endtask

    initial begin
        int n;
        int t;
        for (int i = 0; i < 64; i++) mbuf[i] = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 128'(iomem_ready), 128'd0);
        check("rst_rdata", 128'(iomem_rdata), 128'd0);
        check("rst_b_wren", 128'(b_fifo_wren), 128'd0);
        check("rst_b_din_del", 128'({b_fifo_din, b_fifo_del}), 128'd0);
        check("rst_h_wren", 128'(h_fifo_wren), 128'd0);
        check("rst_h_din", h_fifo_din, 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd("cfg_after_reset", 32'h1500_0000, 32'h0000_002E);

        // foreign region never acknowledged
        iomem_valid = 1'b1;
        iomem_addr  = 32'h2000_0004;
        iomem_wstrb = 4'd0;
        n = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (iomem_ready) n++;
        end
        iomem_valid = 1'b0;
        check("foreign_region_ready", 128'(n), 128'd0);

        // held valid: ready pulses separated by a low cycle
        @(posedge clk);
        #1;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h1500_0000;
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (iomem_ready) n++;
        end
        iomem_valid = 1'b0;
        check("ready_pulses", 128'(n), 128'd3);

        // buffer fill, readback, partial strobes
        fill_buffer();
        rd("buf_rd_w0", 32'h0500_0000, mword(0));
        rd("buf_rd_w7", 32'h0500_001C, mword(7));
        wr(32'h0500_0024, 4'b0101, $urandom);
        rd("buf_partial_w9", 32'h0500_0024, mword(9));

        // 16-byte frame, no backpressure, exact timing
        wr(32'h1500_0000, 4'b1001, 32'h4000_0010);
        t = t_acc;
        goto_edge(t + 17);
        rd("cfg_busy_in_header", 32'h1500_0000, 32'h8000_0010);
        goto_edge(t + 19);
        rd("cfg_idle_at_n_plus_3", 32'h1500_0000, 32'h0000_0010);
        mb = 1'b0;
        check("first_body_edge", 128'(first_body_cyc - t), 128'd1);
        check("header_edge", 128'(hdr_cyc - t), 128'd17);

        // same frame, 3-cycle body stall
        wr(32'h1500_0000, 4'b1000, 32'h4000_0000);
        t = t_acc;
        stall_from = t + 4;
        stall_to   = t + 7;
        wait_idle("cfg_after_stall");
        check("stalled_header_edge", 128'(hdr_cyc - t), 128'd20);

        // zero length send -> error, then clear
        wr(32'h1500_0000, 4'hF, 32'h4000_0000);
        repeat (5) @(posedge clk);
        #1;
        rd("cfg_len0_err", 32'h1500_0000, 32'h0800_0000);
        wr(32'h1500_0000, 4'b1000, 32'h0800_0000);
        rd("cfg_err_cleared", 32'h1500_0000, 32'h0000_0000);

        // oversize length clamps to 48
        fill_buffer();
        wr(32'h1500_0000, 4'b1001, 32'h4000_003C);
        wait_idle("cfg_after_len60");

        // sends and buffer writes while busy are rejected
        wr(32'h1500_0000, 4'b1001, 32'h4000_0014);
        wr(32'h1500_0000, 4'b1000, 32'h4000_0000);
        wr(32'h0500_0014, 4'hF, $urandom);
        rd("buf_rd_while_busy", 32'h0500_0014, mword(5));
        wr(32'h1500_0000, 4'b1000, 32'h4800_0000);
        rd("cfg_busy_err", 32'h1500_0000, mcfg());
        wait_idle("cfg_err_sticky");
        wr(32'h1500_0000, 4'b1000, 32'h0800_0000);

        // random frames under random backpressure
        bp_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            fill_buffer();
            wr(32'h1500_0000, 4'b1001, {8'h40, 17'd0, 7'($urandom_range(1, 60))});
            wait_idle("cfg_random_frame");
        end
        bp_en = 1'b0;

        // reset during body byte 5
        wr(32'h1500_0000, 4'b1001, 32'h4000_0020);
        t = t_acc;
        goto_edge(t + 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        mb    = 1'b0;
        err_m = 1'b0;
        len_m = 7'd46;
        check("rst_mid_b_wren", 128'(b_fifo_wren), 128'd0);
        check("rst_mid_h_wren", 128'(h_fifo_wren), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rd("cfg_after_mid_reset", 32'h1500_0000, 32'h0000_002E);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ctrl_frame_sender.md
CTRL_FRAME_SENDER -- requirements
Module: ctrl_frame_sender

Interface
REQ-001 Parameter HEADER_DWIDTH, default 128: width of the header FIFO word.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 h_fifo_din  output  HEADER_DWIDTH  header word written to TX header FIFO.
REQ-005 h_fifo_wren  output  1  header FIFO write strobe, one cycle per frame.
REQ-006 h_fifo_full  input  1  header FIFO cannot accept a write.
REQ-007 b_fifo_din  output  8  body byte written to TX body FIFO.
REQ-008 b_fifo_wren  output  1  body FIFO write strobe, one byte per asserted cycle.
REQ-009 b_fifo_del  output  1  delimiter, high with the last body byte only.
REQ-010 b_fifo_full  input  1  body FIFO cannot accept a write.
REQ-011 iomem_valid  input  1  picosoc bus request.
REQ-012 iomem_ready  output  1  one-cycle acknowledge.
REQ-013 iomem_wstrb  input  4  byte write strobes; 0 = read.
REQ-014 iomem_addr  input  32  [31:24] selects region, [5:2] selects buffer word.
REQ-015 iomem_wdata  input  32  write data.
REQ-016 iomem_rdata  output  32  registered read data.

Function
REQ-017 Regions: addr[31:24]=8'h15 config register; 8'h05 frame buffer (16 x 32-bit words, byte-strobe writable, readable); other regions SHALL leave iomem_ready low.
REQ-018 Bus: valid && !ready in an owned region -> ready=1 next cycle for exactly one cycle, rdata updated the same edge; back-to-back requests SHALL see ready low between them.
REQ-019 Config read value: [31] busy, [30] 0, [27] err, [6:0] body_len, all other bits 0.
REQ-020 Config write: wstrb[0] writes body_len; wstrb[3] with wdata[30]=1 is a send request; wstrb[3] with wdata[27]=1 clears err.
REQ-021 Send while idle: latches body_len, using the value written in the same transaction if wstrb[0]; body_len 0 -> send ignored, err set; body_len >48 -> clamped to 48.
REQ-022 Send while busy, or any buffer write while busy: ignored, err set; err SHALL take the set when set and clear coincide.
REQ-023 Buffer layout: words 0-3 header, words 4-15 body; body byte k = word[4+k/4] bits [8*(k%4)+7 : 8*(k%4)] (little-endian).
REQ-024 Header word = {endian_swap(w0), endian_swap(w1), endian_swap(w2), endian_swap(w3)}, endian_swap reversing the 4 bytes; bit 114 forced to 1 (control frame), bit 115 forced to 1 (FCS valid), all other bits verbatim.
REQ-025 FSM states IDLE, BODY, HEADER, DONE; IDLE->BODY on accepted send; BODY->HEADER after last byte written; HEADER->DONE after header written; DONE->IDLE after one cycle.
REQ-026 BODY: b_fifo_wren=1 only in cycles where b_fifo_full=0; byte counter advances only on a write; b_fifo_del=1 with byte body_len-1.
REQ-027 HEADER: h_fifo_wren=1 in the first cycle with h_fifo_full=0, exactly once per frame; the body SHALL precede the header, so a consumer never sees a header without a complete body.
REQ-028 busy=1 from the cycle after send acceptance through DONE inclusive.
REQ-029 Timing with no backpressure and send accepted at edge T: body writes T+1..T+N, header write T+N+1, DONE T+N+2, busy=0 at T+N+3.
REQ-030 Buffer reads are permitted while busy and return current contents.

Reset
REQ-031 rst=1: state IDLE; iomem_ready, iomem_rdata, h_fifo_wren, h_fifo_din, b_fifo_wren, b_fifo_din, b_fifo_del, busy and err = 0; body_len = 46; frame buffer contents are not reset.
REQ-032 rst mid-frame: IDLE on the next edge, no further FIFO writes; the partial body is left to the downstream FIFO flush.

Verification
REQ-033 Fill buffer, write config 0x4000_0010 (send, len 16), FIFOs never full -> 16 body writes on consecutive cycles, del on the 16th, one header write with [114]=[115]=1, busy=0 at T+19.
REQ-034 Same frame with b_fifo_full high for 3 cycles mid-body -> no write during the stall, 16 bytes total in order, header after the last byte.
REQ-035 Send with len 0 -> no FIFO writes, config read = 0x0800_0000; write 0x0800_0000 -> err clears.
REQ-036 Send len 60 -> exactly 48 body bytes, del on byte 48.
REQ-037 Second send and a buffer write while busy -> ignored, err=1, first frame unaffected.
REQ-038 rst asserted at body byte 5 -> wren low from the next edge, config read = 0x0000_002E.
